// File: rtl/uart_rx_fifo_if.sv
// FIFO read port of the UART receiver.
// master: reader (drives rd_en); slave: receiver (drives head entry, valid, count).
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 rd_en;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_perr;
  logic                 rd_ferr;
  logic                 rd_valid;
  logic [CW-1:0]        fifo_count;

  modport master (
    output rd_en,
    input  rd_data, rd_perr, rd_ferr,
    input  rd_valid, fifo_count
  );

  modport slave (
    input  rd_en,
    output rd_data, rd_perr, rd_ferr,
    output rd_valid, fifo_count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled majority voting, parity/stop/break checks
// and a first-word-fall-through RX FIFO.
// Ports: PCLK/PRESETn (sync, active-low), RX serial in, baud_div/data_len/
// parity_en/parity_odd/two_stop config, clr_overrun, overrun (sticky),
// break_det (pulse), rd (FIFO read port, slave side).
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             RX,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [3:0]       data_len,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             two_stop,
  input  logic             clr_overrun,
  output logic             overrun,
  output logic             break_det,
  uart_rx_fifo_if.slave    rd
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = DATA_BITS;

  // Sample k of a bit is taken on the k-th tick after the bit start,
  // i.e. when the pre-increment sample counter equals k-1.
  localparam logic [SW-1:0] V0   = SW'(OVERSAMPLE/2 - 2);
  localparam logic [SW-1:0] V1   = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] V2   = SW'(OVERSAMPLE/2);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRK_WAIT
  } state_t;

  state_t state, state_n;

  logic             rx_meta, rxs;
  logic [DIV_W-1:0] tick_cnt, div_eff;
  logic             tick;
  logic [SW-1:0]    samp_cnt;
  logic             v0, v1, maj;
  logic             vote_end, bit_end;
  logic [3:0]       len_sel, len_q, bit_idx;
  logic             pen_q, podd_q, two_q;
  logic             stop_idx, last_stop;
  logic [DW-1:0]    shreg, data_q;
  logic             par_bit, ferr_acc, stop_hi;
  logic             perr_now, frame_brk, frame_done;
  logic             push_q, perr_q, ferr_q, brk_q;

  assign div_eff  = (baud_div == '0) ? DIV_W'(1) : baud_div;
  assign tick     = (tick_cnt == div_eff - DIV_W'(1));
  assign vote_end = tick && (samp_cnt == V2);
  assign bit_end  = tick && (samp_cnt == LAST);
  assign maj      = (v0 & v1) | (v0 & rxs) | (v1 & rxs);

  assign len_sel = (data_len >= 4'd5 && data_len <= 4'(DW))
                   ? data_len : 4'(DW);

  assign last_stop  = !two_q || stop_idx;
  assign perr_now   = pen_q && (par_bit != (^shreg ^ podd_q));
  assign frame_brk  = (shreg == '0) && !(pen_q && par_bit)
                      && !stop_hi && !maj;
  assign frame_done = (state == STOP) && vote_end && last_stop;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (!rxs) state_n = START;
      START: begin
        if (vote_end && maj) state_n = IDLE;
        else if (bit_end)    state_n = DATA;
      end
      DATA: begin
        if (bit_end && bit_idx == len_q - 4'd1)
          state_n = pen_q ? PARITY : STOP;
      end
      PARITY:   if (bit_end) state_n = STOP;
      STOP:     if (frame_done)
                  state_n = frame_brk ? BRK_WAIT : IDLE;
      BRK_WAIT: if (bit_end && rxs) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      tick_cnt <= '0;
      samp_cnt <= '0;
      v0       <= 1'b1;
      v1       <= 1'b1;
      len_q    <= 4'(DW);
      pen_q    <= 1'b0;
      podd_q   <= 1'b0;
      two_q    <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
      stop_hi  <= 1'b0;
      push_q   <= 1'b0;
      data_q   <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      rx_meta <= RX;
      rxs     <= rx_meta;
      push_q  <= 1'b0;

      // Realign the tick phase to the detected start edge.
      if ((state == IDLE && !rxs) || tick) tick_cnt <= '0;
      else tick_cnt <= tick_cnt + DIV_W'(1);

      // In BRK_WAIT the counter measures continuous high time.
      if (state == IDLE || frame_done)        samp_cnt <= '0;
      else if (state == BRK_WAIT && !rxs)     samp_cnt <= '0;
      else if (tick && samp_cnt == LAST)      samp_cnt <= '0;
      else if (tick) samp_cnt <= samp_cnt + SW'(1);

      if (tick && samp_cnt == V0) v0 <= rxs;
      if (tick && samp_cnt == V1) v1 <= rxs;

      if (state == IDLE && !rxs) begin
        len_q    <= len_sel;
        pen_q    <= parity_en;
        podd_q   <= parity_odd;
        two_q    <= two_stop;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        shreg    <= '0;
        par_bit  <= 1'b0;
        ferr_acc <= 1'b0;
        stop_hi  <= 1'b0;
      end

      if (state == DATA && vote_end)
        shreg <= shreg | (DW'(maj) << bit_idx);
      if (state == DATA && bit_end)
        bit_idx <= bit_idx + 4'd1;

      if (state == PARITY && vote_end) par_bit <= maj;

      if (state == STOP && vote_end) begin
        ferr_acc <= ferr_acc | !maj;
        stop_hi  <= stop_hi | maj;
      end
      if (state == STOP && bit_end) stop_idx <= 1'b1;

      if (frame_done) begin
        push_q <= 1'b1;
        data_q <= shreg;
        perr_q <= perr_now;
        ferr_q <= ferr_acc | !maj;
        brk_q  <= frame_brk;
      end
    end
  end

  assign break_det = push_q & brk_q;

  logic [DW+1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          valid, full, pop, push_ok;
  logic [DW+1:0] head;

  assign valid   = (count != '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = rd.rd_en && valid;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push_ok = push_q && (!full || pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge PCLK) begin
    if (push_ok) mem[wr_ptr] <= {perr_q, ferr_q, data_q};
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_q && full && !pop) overrun <= 1'b1;
      else if (clr_overrun)       overrun <= 1'b0;
    end
  end

  assign rd.rd_valid   = valid;
  assign rd.fifo_count = count;
  assign rd.rd_data    = valid ? head[DW-1:0] : '0;
  assign rd.rd_ferr    = valid & head[DW];
  assign rd.rd_perr    = valid & head[DW+1];
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver for the APB UART subsystem. It deserialises the RX line using configurable data width, parity and stop bits. Each frame is checked for start, parity, stop and break conditions. Received bytes and their per-frame error flags are buffered in a first-word-fall-through FIFO that the register block drains.

Parameters:
DATA_BITS, 8, maximum data bits per frame; runtime length selectable 5..DATA_BITS
OVERSAMPLE, 16, sample ticks per bit period; must be even and >= 8
FIFO_DEPTH, 16, RX FIFO entries; must be a power of two
DIV_W, 16, width of the baud divisor

Ports:
PCLK  input  1  clock
PRESETn  input  1  synchronous reset, active-low
RX  input  1  asynchronous serial input; idle level is 1
baud_div  input  DIV_W  PCLK cycles per sample tick; 0 is treated as 1
data_len  input  4  data bits per frame, 5..DATA_BITS; out-of-range values are treated as DATA_BITS
parity_en  input  1  parity bit present
parity_odd  input  1  1 = odd parity, 0 = even parity
two_stop  input  1  1 = two stop bits checked
rd_en  input  1  pop the FIFO head
rd_data  output  DATA_BITS  FIFO head data, zero-extended above data_len
rd_perr  output  1  parity error flag of the head entry
rd_ferr  output  1  framing error flag of the head entry
rd_valid  output  1  FIFO not empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy
overrun  output  1  sticky: a frame was dropped because the FIFO was full
clr_overrun  input  1  clears overrun
break_det  output  1  one-cycle pulse on break detection

Behaviour:
- Reset (PRESETn=0 at a PCLK edge): FSM=IDLE; FIFO empty; rd_valid=0; fifo_count=0; rd_data/rd_perr/rd_ferr=0; overrun=0; break_det=0; synchroniser flops=1; tick counter=0. Config inputs are sampled at START entry only. Reset mid-frame discards the partial frame.
- RX passes through a 2-flop synchroniser; all checks below use the synchronised value rxs.
- Tick generator: counter runs 0..max(baud_div,1)-1 and pulses tick on wrap. It restarts at 0 on IDLE->START so frame timing is phase-aligned to the start edge.
- Each bit value is a majority vote of rxs at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
- FSM states and transitions:
  - IDLE: rxs=0 -> START.
  - START: the bit is evaluated at OVERSAMPLE/2+1 ticks. Vote 1 -> IDLE (false start, nothing pushed). Otherwise continue to the end of the bit period, then -> DATA.
  - DATA: data_len bits, LSB first -> PARITY if parity_en, else STOP.
  - PARITY: one bit; perr = received parity != computed parity (even: XOR of data; odd: inverted XOR).
  - STOP: 1 bit, or 2 bits if two_stop. ferr = any stop-bit vote is 0. Push occurs in the PCLK cycle after the last stop-bit vote, without waiting for the bit end. Then -> IDLE, or -> BRK_WAIT if a break was detected.
  - BRK_WAIT: stay until rxs=1 for one full bit period, then -> IDLE.
- Break: data all 0, parity vote 0 (if enabled) and all stop votes 0. The frame is pushed with data=0 and ferr=1; perr is computed normally. break_det pulses in the push cycle.
- FIFO: first-word-fall-through. rd_data/flags present the head whenever rd_valid=1. rd_en while rd_valid=0 is ignored.
  - Push+pop in the same cycle: both happen; count unchanged. A push onto a full FIFO with rd_en=1 that cycle is accepted.
  - Push onto a full FIFO without a pop: frame dropped, overrun<=1.
  - Pointers wrap modulo FIFO_DEPTH.
  - Latency: push cycle N -> rd_valid/rd_data visible at N+1.
- overrun: set has priority over clr_overrun in the same cycle.
- rd_data bits above data_len read 0.

Test Plan:
- baud_div=4, OVERSAMPLE=16, 8N1, send 0xA5 -> one entry, rd_data=0xA5, perr=0, ferr=0; push 9.5 bit periods (~610 PCLK) after the falling edge, ±1 bit-tick.
- 7E2 (data_len=7, parity_en=1, parity_odd=0, two_stop=1), send 0x35 with a wrong parity bit -> rd_data=0x35, perr=1, ferr=0; then 0x35 with correct parity -> perr=0.
- 8N1, drive a 3-tick low glitch on RX -> FSM returns to IDLE, fifo_count stays 0.
- FIFO_DEPTH=16, 17 frames with no reads -> fifo_count=16 and overrun=1. The head is the first frame and the 17th frame is lost. clr_overrun -> overrun=0.
- RX held low for 12 bit periods, then high -> one entry with data=0, ferr=1, and break_det pulses once. No further frame is received until the line has been high for one bit period.
- Assert PRESETn low mid-DATA and also with rd_en=1 and FIFO full in the same cycle a push completes -> after reset the FIFO is empty and the FSM is IDLE. For the full case without reset: push accepted, count stays 16, overrun stays 0.
